// File: rtl/llr_derate_reader_pkg.sv
// Shared constants and FSM encoding for the PBCH LLR de-rate-matching reader.
package llr_derate_reader_pkg;
    localparam int LLR_WIDTH   = 8;
    localparam int LANES       = 4;
    localparam int E_LEN       = 864;
    localparam int N_LEN       = 512;
    localparam int MEM1_LLRS   = 432;
    localparam int COMB_LIMIT  = E_LEN - N_LEN;
    localparam int MEM2_OFFSET = N_LEN - MEM1_LLRS;
    localparam int ADDR_W      = 7;
    localparam int IDX_W       = 9;
    localparam int WORD_W      = LANES * LLR_WIDTH;

    typedef enum logic [2:0] {IDLE, RD, CAP, STRM, DONE} state_t;
endpackage

// File: rtl/llr_derate_reader_if.sv
// LLR memory read ports plus the output stream towards the polar decoder.
interface llr_derate_reader_if;
    import llr_derate_reader_pkg::*;

    logic [ADDR_W-1:0]           mem_1_r_addr;
    logic                        mem_1_r_enable;
    logic [WORD_W-1:0]           mem_1_r_data;
    logic [ADDR_W-1:0]           mem_2_r_addr;
    logic                        mem_2_r_enable;
    logic [WORD_W-1:0]           mem_2_r_data;
    logic signed [LLR_WIDTH-1:0] llr_out;
    logic [IDX_W-1:0]            llr_out_index;
    logic                        llr_out_valid;
    logic                        llr_out_ready;

    modport master (
        output mem_1_r_addr, mem_1_r_enable, mem_2_r_addr, mem_2_r_enable,
               llr_out, llr_out_index, llr_out_valid,
        input  mem_1_r_data, mem_2_r_data, llr_out_ready
    );
    modport slave (
        input  mem_1_r_addr, mem_1_r_enable, mem_2_r_addr, mem_2_r_enable,
               llr_out, llr_out_index, llr_out_valid,
        output mem_1_r_data, mem_2_r_data, llr_out_ready
    );
endinterface

// File: rtl/llr_derate_reader_sat_add.sv
// Signed saturating add of two LLRs: widen by one bit, add, clamp to range.
module llr_sat_add #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    logic signed [W:0] sum;

    assign sum = {a[W-1], a} + {b[W-1], b};

    always_comb begin
        y = sum[W-1:0];
        // Top two bits differ only when the result left the W-bit range.
        if (sum[W] != sum[W-1])
            y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
endmodule

// File: rtl/llr_derate_reader.sv
// Reads the two channel-LLR RAMs word by word, folds repeated LLRs back onto
// the 512-entry mother code, and streams the result over valid/ready.
module llr_derate_reader
    import llr_derate_reader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    llr_derate_reader_if.master bus,
    output logic                derm_done,
    output logic                busy
);
    localparam logic [IDX_W-1:0] COMB_K = IDX_W'(COMB_LIMIT);
    localparam logic [IDX_W-1:0] M1_K   = IDX_W'(MEM1_LLRS);
    localparam logic [IDX_W-1:0] OFF_K  = IDX_W'(MEM2_OFFSET);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_LEN - 1);

    state_t                      state, state_nx;
    logic [IDX_W-1:0]            k, k2;
    logic [WORD_W-1:0]           word_1, word_2;
    logic [ADDR_W-1:0]           addr_1_q, addr_2_q, addr_1_rd, addr_2_rd;
    logic                        comb, use_1, use_2;
    logic [1:0]                  lane;
    logic signed [LLR_WIDTH-1:0] llr_1, llr_2, llr_sum;

    // Region boundaries are multiples of 4, so a whole word shares one source mix.
    assign comb  = k < COMB_K;
    assign use_1 = k < M1_K;
    assign use_2 = comb || !use_1;
    assign k2    = comb ? k + OFF_K : k - M1_K;

    assign addr_1_rd = k[IDX_W-1:2];
    assign addr_2_rd = k2[IDX_W-1:2];
    assign lane      = k[1:0];
    assign llr_1     = word_1[lane*LLR_WIDTH +: LLR_WIDTH];
    assign llr_2     = word_2[lane*LLR_WIDTH +: LLR_WIDTH];

    llr_sat_add #(.W(LLR_WIDTH)) u_sat (.a(llr_1), .b(llr_2), .y(llr_sum));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k        <= '0;
            addr_1_q <= '0;
            addr_2_q <= '0;
            word_1   <= '0;
            word_2   <= '0;
        end else begin
            case (state)
                IDLE: if (start) k <= '0;
                RD: begin
                    if (use_1) addr_1_q <= addr_1_rd;
                    if (use_2) addr_2_q <= addr_2_rd;
                end
                // Read data is only present in this cycle.
                CAP: begin
                    word_1 <= bus.mem_1_r_data;
                    word_2 <= bus.mem_2_r_data;
                end
                STRM: if (bus.llr_out_ready) k <= k + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx           = state;
        bus.mem_1_r_addr   = addr_1_q;
        bus.mem_2_r_addr   = addr_2_q;
        bus.mem_1_r_enable = 1'b0;
        bus.mem_2_r_enable = 1'b0;
        bus.llr_out        = '0;
        bus.llr_out_index  = '0;
        bus.llr_out_valid  = 1'b0;
        derm_done          = 1'b0;
        busy               = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RD;
            RD: begin
                busy               = 1'b1;
                bus.mem_1_r_enable = use_1;
                bus.mem_2_r_enable = use_2;
                if (use_1) bus.mem_1_r_addr = addr_1_rd;
                if (use_2) bus.mem_2_r_addr = addr_2_rd;
                state_nx           = CAP;
            end
            CAP: begin
                busy     = 1'b1;
                state_nx = STRM;
            end
            STRM: begin
                busy              = 1'b1;
                bus.llr_out_valid = 1'b1;
                bus.llr_out_index = k;
                bus.llr_out       = comb ? llr_sum : (use_1 ? llr_1 : llr_2);
                if (bus.llr_out_ready) begin
                    if (k == LAST_K)     state_nx = DONE;
                    else if (lane == 2'd3) state_nx = RD;
                end
            end
            DONE: begin
                derm_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_llr_derate_reader.sv
// Scoreboard bench: a reference model of the de-rate-matching rules queues the
// expected stream; a negedge monitor checks outputs, holds and memory strobes.
module tb_llr_derate_reader;
    import llr_derate_reader_pkg::*;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic derm_done, busy;

    llr_derate_reader_if bus();

    llr_derate_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .bus(bus.master), .derm_done(derm_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int          llr [E_LEN];
    logic [31:0] m1 [128];
    logic [31:0] m2 [128];
    exp_t        q [$];

    int total = 0, bad = 0;
    int n_acc = 0, n_rd = 0, n_done = 0;
    bit sat_pass = 0;
    bit hold_pend = 0;
    int last_llr, last_idx;
    int lat, done_cyc;

    // Memory model: data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        bus.mem_1_r_data <= bus.mem_1_r_enable ? m1[bus.mem_1_r_addr] : $urandom;
        bus.mem_2_r_data <= bus.mem_2_r_enable ? m2[bus.mem_2_r_addr] : $urandom;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic load(input int pat);
        int idx;
        for (int i = 0; i < E_LEN; i++)
            llr[i] = (pat == 0) ? (i % 100) - 50 : int'($urandom_range(0, 255)) - 128;
        if (pat == 1) begin
            llr[5] = 100;  llr[517] = 90;
            llr[6] = -100; llr[518] = -90;
        end
        for (int w = 0; w < 128; w++) begin
            m1[w] = $urandom;
            m2[w] = $urandom;
            for (int j = 0; j < LANES; j++) begin
                idx = 4 * w + j;
                if (idx < MEM1_LLRS)         m1[w][8*j +: 8] = 8'(llr[idx]);
                if (idx + MEM1_LLRS < E_LEN) m2[w][8*j +: 8] = 8'(llr[idx + MEM1_LLRS]);
            end
        end
        q.delete();
        for (int kk = 0; kk < N_LEN; kk++)
            q.push_back('{kk, (kk < COMB_LIMIT) ? sat(llr[kk] + llr[kk + N_LEN]) : llr[kk]});
        n_acc = 0; n_rd = 0; n_done = 0;
    endtask

    // Monitor
    always @(negedge clk) begin
        int hk, got;
        bit e1, e2;
        exp_t e;
        if (rst) begin
            if (bus.mem_1_r_enable || bus.mem_2_r_enable) begin
                n_rd++;
                hk = (q.size() > 0) ? q[0].idx : -1;
                e1 = (hk >= 0) && (hk < MEM1_LLRS);
                e2 = (hk >= 0) && (hk < COMB_LIMIT || hk >= MEM1_LLRS);
                check("mem_1_r_enable", int'(bus.mem_1_r_enable), int'(e1));
                check("mem_2_r_enable", int'(bus.mem_2_r_enable), int'(e2));
                if (e1) check("mem_1_r_addr", int'(bus.mem_1_r_addr), hk / 4);
                if (e2) check("mem_2_r_addr", int'(bus.mem_2_r_addr),
                              (hk < COMB_LIMIT) ? (hk + N_LEN - MEM1_LLRS) / 4 : (hk - MEM1_LLRS) / 4);
            end
            got = int'($signed(bus.llr_out));
            if (bus.llr_out_valid) begin
                if (hold_pend) begin
                    check("hold_llr", got, last_llr);
                    check("hold_index", int'(bus.llr_out_index), last_idx);
                end
                if (bus.llr_out_ready) begin
                    n_acc++;
                    if (q.size() == 0) check("extra_output", int'(bus.llr_out_index), -1);
                    else begin
                        e = q.pop_front();
                        check("llr_out_index", int'(bus.llr_out_index), e.idx);
                        check("llr_out", got, e.val);
                        if (sat_pass && e.idx == 5) check("sat_pos", got, 127);
                        if (sat_pass && e.idx == 6) check("sat_neg", got, -128);
                    end
                end
                hold_pend = !bus.llr_out_ready;
                last_llr  = got;
                last_idx  = int'(bus.llr_out_index);
            end else begin
                if (hold_pend) check("valid_dropped", 0, 1);
                hold_pend = 0;
            end
            if (derm_done) begin
                n_done++;
                check("done_queue_empty", q.size(), 0);
            end
        end else hold_pend = 0;
    end

    task automatic run_pass(input bit rand_rdy, input bit inject);
        int cyc;
        lat = -1; done_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        while (cyc < 4000) begin
            if (bus.llr_out_valid && lat < 0) lat = cyc;
            if (derm_done) begin done_cyc = cyc; break; end
            bus.llr_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start = inject && (cyc == 100 || cyc == 101);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.llr_out_ready = 1'b1;
        check("first_valid_latency", lat, 3);
        if (!rand_rdy) check("done_cycle", done_cyc, 769);
        else           check("done_seen", int'(done_cyc > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", n_done, 1);
        check("word_reads", n_rd, 128);
        check("outputs", n_acc, 512);
        check("busy_after", int'(busy), 0);
    endtask

    initial begin
        int cyc;
        bus.llr_out_ready = 1'b1;
        rst = 1'b0; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(bus.llr_out_valid), 0);
        check("rst_llr", int'(bus.llr_out), 0);
        check("rst_index", int'(bus.llr_out_index), 0);
        check("rst_en1", int'(bus.mem_1_r_enable), 0);
        check("rst_en2", int'(bus.mem_2_r_enable), 0);
        check("rst_addr1", int'(bus.mem_1_r_addr), 0);
        check("rst_addr2", int'(bus.mem_2_r_addr), 0);
        check("rst_done", int'(derm_done), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_busy", int'(busy), 0);

        // Ramp pattern, ready held high
        load(0);
        run_pass(1'b0, 1'b0);

        // Random LLRs with saturating pairs, random backpressure, stray start
        sat_pass = 1;
        load(1);
        run_pass(1'b1, 1'b1);
        sat_pass = 0;

        // Abort at k=200
        load(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (n_acc < 200 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check("abort_reached", n_acc, 200);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(bus.llr_out_valid), 0);
        rst = 1'b1;
        q.delete();
        repeat (4) @(posedge clk);
        #1 check("abort_no_done", n_done, 0);

        // Fresh pass after the abort
        load(1);
        run_pass(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
